// File: rtl/aes_pipeline_ingress.sv
// Purpose : AES ingress stage. Holds plaintext/key beats in a 2-entry skid FIFO,
//           applies the round-0 AddRoundKey, feeds round 1, and tracks block validity to the pipeline output.
// Latency : 1 cycle from an accepted beat to stage_valid when the FIFO is empty and credit
//           is available. pipe_valid follows stage_valid by PIPE_DEPTH cycles.
// Backpres: issue waits for egress credits. in_ready drops only when both FIFO entries are full.
//
// Ports:
//   clock, reset           - rising-edge clock, synchronous active-high reset
//   in_valid/in_ready      - upstream valid/ready handshake; in_data, in_key captured together
//   stage_out/stage_valid  - registered in_data ^ in_key to round 1, or zero bubble
//   pipe_valid             - final-round valid, PIPE_DEPTH cycles after stage_valid
//   credit_return          - egress popped one entry
//   credits_avail          - current credit count
//   credit_err             - sticky over-return flag
//   idle                   - no buffered or in-flight blocks
//   accepted_count, stall_cycles - saturating statistics
//
// Build option: define INGRESS_STATS_EN to enable the statistics counters.
//               Without it, both counter ports are tied to zero.

module aes_pipeline_ingress #(
   parameter int PIPE_DEPTH = 10,
   parameter int CREDITS    = 4
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [127:0]                     in_data,
   input  logic [127:0]                     in_key,
   output logic [127:0]                     stage_out,
   output logic                             stage_valid,
   output logic                             pipe_valid,
   input  logic                             credit_return,
   output logic [$clog2(CREDITS+1)-1:0]     credits_avail,
   output logic                             credit_err,
   output logic                             idle,
   output logic [31:0]                      accepted_count,
   output logic [31:0]                      stall_cycles
);

   localparam int CW = $clog2(CREDITS+1);
   localparam int IW = $clog2(PIPE_DEPTH+2);
   localparam logic [CW-1:0] CREDITS_MAX = CW'(CREDITS);

   // The FIFO stores the pre-XORed state. Only data ^ key is consumed downstream.
   logic [127:0]            mem_q [2];
   logic                    rd_ptr_q, rd_ptr_d;
   logic                    wr_ptr_q, wr_ptr_d;
   logic [1:0]              occ_q, occ_d;

   logic [127:0]            stage_out_q, stage_out_d;
   logic                    stage_valid_q, stage_valid_d;
   logic [PIPE_DEPTH-1:0]   vld_q, vld_d;
   logic [CW-1:0]           credits_q, credits_d;
   logic                    err_q, err_d;
   logic [IW-1:0]           inflight_q, inflight_d;

   logic                    accept;
   logic                    fifo_empty;
   logic                    issue;
   logic                    bypass;
   logic                    push;
   logic                    pop;
   logic [127:0]            issue_dat;

   // in_ready depends only on registered occupancy. There is no path from in_valid.
   assign in_ready   = (occ_q != 2'd2);
   assign accept     = in_valid && in_ready;
   assign fifo_empty = (occ_q == 2'd0);

   // With an empty FIFO the incoming beat is the source. in_ready is 1 then, so in_valid means accept.
   assign issue      = (!fifo_empty || in_valid) && (credits_q != '0);
   assign bypass     = fifo_empty && issue;
   assign push       = accept && !bypass;
   assign pop        = issue && !fifo_empty;
   assign issue_dat  = fifo_empty ? (in_data ^ in_key) : mem_q[rd_ptr_q];

   always_comb begin
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      occ_d         = occ_q;
      stage_out_d   = '0;
      stage_valid_d = 1'b0;
      credits_d     = credits_q;
      err_d         = err_q;
      inflight_d    = inflight_q;
      vld_d         = (vld_q << 1) | PIPE_DEPTH'(stage_valid_q);

      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase

      if (issue) begin
         stage_out_d   = issue_dat;
         stage_valid_d = 1'b1;
      end

      // A return in the same cycle as an issue cancels out, so it is never an over-return.
      if (issue && !credit_return) begin
         credits_d = credits_q - 1'b1;
      end else if (!issue && credit_return) begin
         if (credits_q == CREDITS_MAX) err_d = 1'b1;
         else                          credits_d = credits_q + 1'b1;
      end

      if (issue && !pipe_valid)      inflight_d = inflight_q + 1'b1;
      else if (!issue && pipe_valid) inflight_d = inflight_q - 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr_q      <= 1'b0;
         wr_ptr_q      <= 1'b0;
         occ_q         <= 2'd0;
         stage_out_q   <= '0;
         stage_valid_q <= 1'b0;
         vld_q         <= '0;
         credits_q     <= CREDITS_MAX;
         err_q         <= 1'b0;
         inflight_q    <= '0;
      end else begin
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         occ_q         <= occ_d;
         stage_out_q   <= stage_out_d;
         stage_valid_q <= stage_valid_d;
         vld_q         <= vld_d;
         credits_q     <= credits_d;
         err_q         <= err_d;
         inflight_q    <= inflight_d;
      end
   end

   // FIFO storage is pure datapath. Occupancy alone decides which entries are meaningful.
   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= in_data ^ in_key;
   end

   assign stage_out     = stage_out_q;
   assign stage_valid   = stage_valid_q;
   assign pipe_valid    = vld_q[PIPE_DEPTH-1];
   assign credits_avail = credits_q;
   assign credit_err    = err_q;
   assign idle          = fifo_empty && (inflight_q == '0) && !stage_valid_q;

`ifdef INGRESS_STATS_EN
   logic [31:0] acc_cnt_q, acc_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      acc_cnt_d   = acc_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (accept && (acc_cnt_q != 32'hFFFF_FFFF))
         acc_cnt_d = acc_cnt_q + 32'd1;
      if (in_valid && !in_ready && (stall_cnt_q != 32'hFFFF_FFFF))
         stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         acc_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         acc_cnt_q   <= acc_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign accepted_count = acc_cnt_q;
   assign stall_cycles   = stall_cnt_q;
`else
   assign accepted_count = 32'd0;
   assign stall_cycles   = 32'd0;
`endif

endmodule

// File: tb/tb_aes_pipeline_ingress.sv
// Purpose : self-checking bench for aes_pipeline_ingress, combining queue-based reference model
//           with scoreboard for stage_out ordering and data.
// Latency : model predicts stage_valid one edge after issue and pipe_valid PIPE_DEPTH edges later.
// Backpres: the upstream driver holds a beat until it is accepted. Credits are returned at random.

module tb_aes_pipeline_ingress;
   localparam int PIPE_DEPTH = 10;
   localparam int CREDITS    = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [127:0]  in_data = '0;
   logic [127:0]  in_key = '0;
   logic [127:0]  stage_out;
   logic          stage_valid;
   logic          pipe_valid;
   logic          credit_return = 1'b0;
   logic [$clog2(CREDITS+1)-1:0] credits_avail;
   logic          credit_err;
   logic          idle;
   logic [31:0]   accepted_count;
   logic [31:0]   stall_cycles;

   aes_pipeline_ingress #(.PIPE_DEPTH(PIPE_DEPTH), .CREDITS(CREDITS)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
      .stage_out(stage_out), .stage_valid(stage_valid), .pipe_valid(pipe_valid),
      .credit_return(credit_return), .credits_avail(credits_avail), .credit_err(credit_err),
      .idle(idle), .accepted_count(accepted_count), .stall_cycles(stall_cycles)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Reference model state: blocks waiting for issue, expected stage_out order,
   // edge numbers at which each issued block must show pipe_valid.
   logic [127:0] pend[$];
   logic [127:0] exp_q[$];
   int           due[$];
   int           m_credits = CREDITS;
   bit           m_err = 1'b0;
   bit           m_sv = 1'b0;
   int           m_acc = 0;
   int           m_stall = 0;
   int           edge_n = 1;

   bit           hold_v = 1'b0;
   logic [127:0] hold_d = '0;
   logic [127:0] hold_k = '0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   task automatic check_state();
      bit exp_pv;
      chk("in_ready", in_ready, pend.size() < 2);
      chk("credits_avail", credits_avail, m_credits);
      chk("credit_err", credit_err, m_err);
      chk("stage_valid", stage_valid, m_sv);
      chk("idle", idle, (pend.size() == 0) && (due.size() == 0));
      exp_pv = (due.size() > 0) && (due[0] == edge_n);
      chk("pipe_valid", pipe_valid, exp_pv);
      if (exp_pv) void'(due.pop_front());
`ifdef INGRESS_STATS_EN
      chk("accepted_count", accepted_count, m_acc);
      chk("stall_cycles", stall_cycles, m_stall);
`else
      chk("accepted_count", accepted_count, 0);
      chk("stall_cycles", stall_cycles, 0);
`endif
   endtask

   // One clock: check outputs left by the previous edge, drive inputs, then advance the model.
   task automatic cycle(input bit iv, input logic [127:0] d, input logic [127:0] k,
                        input bit ret, input bit rst, output bit acc);
      bit ready;
      bit iss;
      @(negedge clock);
      check_state();
      in_valid = iv; in_data = d; in_key = k; credit_return = ret; reset = rst;
      edge_n++;
      acc = 1'b0;
      if (rst) begin
         pend.delete(); exp_q.delete(); due.delete();
         m_credits = CREDITS; m_err = 1'b0; m_sv = 1'b0; m_acc = 0; m_stall = 0;
         return;
      end
      ready = pend.size() < 2;
      acc   = iv && ready;
      if (iv && !ready) m_stall++;
      if (acc) begin
         m_acc++;
         pend.push_back(d ^ k);
      end
      iss = (pend.size() > 0) && (m_credits > 0);
      if (iss) begin
         exp_q.push_back(pend.pop_front());
         due.push_back(edge_n + PIPE_DEPTH);
      end
      m_sv = iss;
      if (iss && !ret) m_credits--;
      else if (!iss && ret) begin
         if (m_credits == CREDITS) m_err = 1'b1;
         else                      m_credits++;
      end
   endtask

   // Upstream source honouring valid/ready: a random beat is held until accepted.
   task automatic drive(input bit want, input bit ret, input bit rst);
      bit acc;
      if (rst) hold_v = 1'b0;
      else if (!hold_v && want) begin
         hold_d = {$urandom, $urandom, $urandom, $urandom};
         hold_k = {$urandom, $urandom, $urandom, $urandom};
         hold_v = 1'b1;
      end
      cycle(hold_v, hold_d, hold_k, ret, rst, acc);
      if (acc) hold_v = 1'b0;
   endtask

   // Scoreboard monitor: every presented block must be the oldest expected one.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (stage_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL stage_out: got %h expected no block", stage_out);
            end else begin
               chk("stage_out", stage_out, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL timeout: got no finish expected finish within budget");
      $fatal(1, "timeout");
   end

   initial begin
      bit a;
      int pv;

      repeat (3) drive(0, 0, 1);

      // FIPS-197 round-0 vector.
      cycle(1, 128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f, 0, 0, a);
      cycle(0, '0, '0, 0, 0, a);
      chk("fips_stage_out", stage_out, 128'h00102030405060708090a0b0c0d0e0f0);
      chk("fips_stage_valid", stage_valid, 1);
      repeat (14) cycle(0, '0, '0, 0, 0, a);
      chk("fips_idle", idle, 1);

      // Credit exhaustion with 8 back-to-back beats.
      drive(0, 0, 1);
      repeat (8) drive(1, 0, 0);
      drive(0, 0, 0);
      chk("exh_credits", credits_avail, 0);
      chk("exh_ready", in_ready, 0);
      drive(0, 1, 0);
      drive(0, 0, 0);
      drive(0, 0, 0);
      chk("exh_ready_back", in_ready, 1);
      chk("exh_issue", stage_valid, 1);
      repeat (25) drive(0, m_credits < CREDITS, 0);

      // Simultaneous issue and credit return at 2 credits.
      drive(0, 0, 1);
      repeat (2) drive(1, 0, 0);
      drive(1, 1, 0);
      drive(0, 0, 0);
      chk("simul_credits", credits_avail, 2);
      repeat (14) drive(0, 0, 0);

      // Spurious credit return at full credits.
      drive(0, 0, 1);
      drive(0, 1, 0);
      drive(0, 0, 0);
      chk("spur_err", credit_err, 1);
      chk("spur_credits", credits_avail, CREDITS);
      repeat (5) drive(0, 0, 0);
      chk("spur_err_held", credit_err, 1);

      // Reset with 2 buffered beats and 3 blocks in flight.
      drive(0, 0, 1);
      drive(1, 0, 0);
      repeat (13) drive(0, 0, 0);
      repeat (5) drive(1, 0, 0);
      drive(0, 0, 1);
      drive(0, 0, 0);
      chk("rst_stage_valid", stage_valid, 0);
      chk("rst_credits", credits_avail, CREDITS);
      chk("rst_ready", in_ready, 1);
      chk("rst_idle", idle, 1);
      pv = 0;
      repeat (15) begin
         drive(0, 0, 0);
         if (pipe_valid) pv++;
      end
      chk("rst_no_pipe_valid", pv, 0);

      // Statistics: 6 accepted beats fill credits and FIFO, then 3 stall cycles.
      drive(0, 0, 1);
      repeat (9) drive(1, 0, 0);
      drive(0, 0, 0);
`ifdef INGRESS_STATS_EN
      chk("stats_accepted", accepted_count, 6);
      chk("stats_stalls", stall_cycles, 3);
`else
      chk("stats_accepted_off", accepted_count, 0);
      chk("stats_stalls_off", stall_cycles, 0);
`endif

      // Randomized traffic with random credit returns and occasional resets.
      drive(0, 0, 1);
      repeat (600) begin
         drive($urandom_range(3, 0) != 0,
               (m_credits < CREDITS) ? ($urandom_range(1, 0) == 1) : ($urandom_range(63, 0) == 0),
               $urandom_range(299, 0) == 0);
      end
      repeat (30) drive(0, m_credits < CREDITS, 0);
      chk("drain_scoreboard_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
